// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: bundles the redirect, instruction-memory and IF/ID
// handshake signals of the instruction prefetch queue.
// master = the prefetch queue itself; slave = the surrounding pipeline/memory.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    // Redirect (branch / jalr flush)
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    // Instruction memory request/response
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    // IF/ID delivery handshake
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    modport master (
        input  redirect,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch front-end feeding the IF/ID register.
// Issues sequential word fetches (one outstanding at a time), buffers returned
// words with their PCs in a DEPTH-entry FIFO and hands them to IF/ID over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch; a
// request still outstanding at redirect time has its response discarded.
// Build option: define IPQ_BYPASS_EN to let a returning word reach IF/ID in the
// same cycle when the FIFO is empty; otherwise all outputs come from registers.
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_prefetch_queue_if.master bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    // IDLE: nothing outstanding. WAIT: request outstanding, response wanted.
    // DROP: request outstanding but made stale by a redirect; discard its response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [DEPTH-1:0]   slot_we;
    logic               fifo_empty, fifo_full;
    logic               pop_en, push_en;
    logic               issue, req, ack_fire, accept;
    logic [ADDR_W-1:0]  imem_addr;

    assign wr_idx     = wr_ptr_q[IDX_W-1:0];
    assign rd_idx     = rd_ptr_q[IDX_W-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);

    // A redirect cancels the head, so no pop is taken in that cycle.
    assign pop_en = rst && !fifo_empty && bus.if_ready && !bus.redirect;

    // New request only from IDLE; a full FIFO may still issue when the head
    // leaves this same cycle, which keeps zero-wait memory at 1 word/cycle.
    assign issue = rst && (state_q == ST_IDLE) && !bus.redirect && (!fifo_full || pop_en);

    // An outstanding request (WAIT or DROP) keeps req/addr asserted until ack.
    assign req       = issue || (rst && (state_q != ST_IDLE));
    assign imem_addr = (state_q == ST_IDLE) ? fetch_pc_q : req_addr_q;
    assign ack_fire  = req && bus.imem_ack;

    // A response is kept unless it belongs to a stale request or a redirect
    // arrives with it.
    assign accept = ack_fire && (state_q != ST_DROP) && !bus.redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = imem_addr;

`ifdef IPQ_BYPASS_EN
    logic bypass_hit;

    // Empty FIFO: the returning word goes straight to IF/ID and is only
    // buffered if IF/ID does not take it this cycle.
    assign bypass_hit   = accept && fifo_empty;
    assign push_en      = accept && !(bypass_hit && bus.if_ready);
    assign bus.if_valid = !fifo_empty || bypass_hit;
    assign bus.if_instr = bypass_hit ? bus.imem_rdata : instr_mem_q[rd_idx];
    assign bus.if_pc    = bypass_hit ? imem_addr      : pc_mem_q[rd_idx];
`else
    assign push_en      = accept;
    assign bus.if_valid = !fifo_empty;
    assign bus.if_instr = instr_mem_q[rd_idx];
    assign bus.if_pc    = pc_mem_q[rd_idx];
`endif

    // Per-slot write enables decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // Fetch FSM next state: track the single outstanding request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue && !bus.imem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_fire) begin
                    state_d = ST_IDLE;
                end else if (bus.redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (ack_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next state: fetch PC, held request address and FIFO pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (issue) begin
            req_addr_d = fetch_pc_q;
        end
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & WORD_MASK;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC & WORD_MASK;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage: each slot captures the word and its PC when written;
    // cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end else if (slot_we[i]) begin
                pc_mem_q[i]    <= imem_addr;
                instr_mem_q[i] <= bus.imem_rdata;
            end
        end
    end

    // The request throttle must never let a word arrive into a full FIFO
    // unless the head leaves in the same cycle.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst) !(push_en && fifo_full && !pop_en)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed bench for instr_prefetch_queue with a
// variable-latency memory model. Memory word at address A is {16'hC0DE, A[15:0]}.
`timescale 1ns/1ps
module tb_instr_prefetch_queue;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instr_prefetch_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory model: acknowledges after 'lat' wait cycles (0 = same cycle).
    int lat = 0;
    int wait_cnt = 0;
    assign bus.imem_ack   = rst && bus.imem_req && (wait_cnt >= lat);
    assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

    always @(posedge clk) begin
        if (!rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                                       wait_cnt <= wait_cnt + 1;
    end

    // Delivery / ack monitor, sampled mid-cycle after inputs have settled.
    logic [63:0] got_pc[$];
    logic [31:0] got_instr[$];
    int ack_cnt = 0;
    always begin
        @(negedge clk);
        #2;
        if (rst && bus.if_valid && bus.if_ready && !bus.redirect) begin
            got_pc.push_back(bus.if_pc);
            got_instr.push_back(bus.if_instr);
        end
        if (bus.imem_ack) ack_cnt++;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    logic [63:0] t1_pc    [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    logic [31:0] t1_instr [4] = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C};
    logic [63:0] t2_pc    [5] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
    logic [31:0] t2_instr [5] = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C, 32'hC0DE0010};

    int base;
    int ack_base;

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b1;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req",   64'(bus.imem_req), 64'd0);
        check("rst_valid", 64'(bus.if_valid), 64'd0);
        check("rst_instr", 64'(bus.if_instr), 64'd0);
        check("rst_pc",    bus.if_pc,         64'd0);

        // Test 1: zero-wait streaming from RESET_PC
        @(negedge clk); rst = 1'b1; #1;
        check("t1_req",  64'(bus.imem_req), 64'd1);
        check("t1_addr", bus.imem_addr,     64'h0);
`ifndef IPQ_BYPASS_EN
        check("t1_latency", 64'(bus.if_valid), 64'd0);
        @(negedge clk); #1;
`endif
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", 64'(bus.if_valid), 64'd1);
            check("t1_pc",    bus.if_pc,         t1_pc[i]);
            check("t1_instr", 64'(bus.if_instr), 64'(t1_instr[i]));
            @(negedge clk); #1;
        end

        // Test 2: IF/ID stalled for 10 cycles fills the FIFO
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h0; bus.if_ready = 1'b0;
        @(negedge clk); bus.redirect = 1'b0; #1;
        ack_base = ack_cnt;
        repeat (9) @(negedge clk);
        #1;
        check("t2_acks",     64'(ack_cnt - ack_base), 64'd4);
        check("t2_req_low",  64'(bus.imem_req),       64'd0);
        check("t2_valid",    64'(bus.if_valid),       64'd1);
        check("t2_head_pc",  bus.if_pc,               64'h0);

        // Test 5: full FIFO, pop and zero-wait ack in the same cycle
        @(negedge clk); bus.if_ready = 1'b1; #1;
        base = got_pc.size();
        check("t5_req",  64'(bus.imem_req), 64'd1);
        check("t5_addr", bus.imem_addr,     64'h10);
        check("t5_ack",  64'(bus.imem_ack), 64'd1);
        @(negedge clk); bus.if_ready = 1'b0; #1;
        check("t5_still_full", 64'(bus.imem_req), 64'd0);
        check("t5_head_pc",    bus.if_pc,         64'h4);
        @(negedge clk); bus.if_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t2_order_pc",    got_pc[base + k],         t2_pc[k]);
            check("t2_order_instr", 64'(got_instr[base + k]), 64'(t2_instr[k]));
        end

        // Test 3: redirect with 3 entries queued
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h0; bus.if_ready = 1'b0;
        @(negedge clk); bus.redirect = 1'b0;
        repeat (3) @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h103; bus.if_ready = 1'b1; #1;
        base = got_pc.size();
        check("t3_pre_valid", 64'(bus.if_valid), 64'd1);
        check("t3_pre_pc",    bus.if_pc,         64'h0);
        check("t3_no_req",    64'(bus.imem_req), 64'd0);
        @(negedge clk); bus.redirect = 1'b0; #1;
        check("t3_addr", bus.imem_addr, 64'h100);
`ifdef IPQ_BYPASS_EN
        check("t3_bypass_valid", 64'(bus.if_valid), 64'd1);
        check("t3_bypass_pc",    bus.if_pc,         64'h100);
`else
        check("t3_flushed", 64'(bus.if_valid), 64'd0);
`endif
        repeat (3) @(negedge clk);
        #1;
        check("t3_first_pc",    got_pc[base],         64'h100);
        check("t3_first_instr", 64'(got_instr[base]), 64'hC0DE0100);
        check("t3_second_pc",   got_pc[base + 1],     64'h104);

        // Test 4: 3-cycle memory, redirect while the request to 0x10 is pending
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h10; lat = 3;
        @(negedge clk); bus.redirect = 1'b0; #1;
        check("t4_req",   64'(bus.imem_req), 64'd1);
        check("t4_addr",  bus.imem_addr,     64'h10);
        check("t4_noack", 64'(bus.imem_ack), 64'd0);
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 64'h200; #1;
        check("t4_hold_addr", bus.imem_addr, 64'h10);
        @(negedge clk); bus.redirect = 1'b0; #1;
        base = got_pc.size();
        check("t4_drop_req",  64'(bus.imem_req), 64'd1);
        check("t4_drop_addr", bus.imem_addr,     64'h10);
        @(negedge clk); #1;
        check("t4_stale_ack",   64'(bus.imem_ack), 64'd1);
        check("t4_stale_valid", 64'(bus.if_valid), 64'd0);
        @(negedge clk); #1;
        check("t4_new_addr", bus.imem_addr, 64'h200);
        repeat (10) @(negedge clk);
        #1;
        check("t4_first_pc",    got_pc[base],         64'h200);
        check("t4_first_instr", 64'(got_instr[base]), 64'hC0DE0200);
        check("t4_second_pc",   got_pc[base + 1],     64'h204);

        // Test 6: empty FIFO, zero-wait ack at 0x40
        @(negedge clk); lat = 0;
        repeat (3) @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h40;
        @(negedge clk); bus.redirect = 1'b0; #1;
        check("t6_addr", bus.imem_addr,     64'h40);
        check("t6_ack",  64'(bus.imem_ack), 64'd1);
`ifdef IPQ_BYPASS_EN
        check("t6_valid", 64'(bus.if_valid), 64'd1);
        check("t6_pc",    bus.if_pc,         64'h40);
        check("t6_instr", 64'(bus.if_instr), 64'hC0DE0040);
`else
        check("t6_not_yet", 64'(bus.if_valid), 64'd0);
        @(negedge clk); #1;
        check("t6_valid", 64'(bus.if_valid), 64'd1);
        check("t6_pc",    bus.if_pc,         64'h40);
        check("t6_instr", 64'(bus.if_instr), 64'hC0DE0040);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
